uart_rx: RTL and testbench

//  Serial-to-parallel UART receiver that consumes the single-cycle tick from the baud rate generator.
//  - The tick (s_tick) runs at 16x the bit rate.
//  - Frame format: 1 start bit, DBIT data bits sent LSB first, 1 stop bit, no parity.
//  - Sits between the rx pad and the receive FIFO / host logic.
//  - Mirrors the transmit path that shares the same tick source.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and oversampling constants for the receive and transmit paths.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pad; 2 clk latency, resets to idle-high.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled: 1 start, DBIT data LSB first, stop of SB_TICK ticks.
// rx_done_tick pulses one clk after the final stop tick; no backpressure, words are overwritten.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            framing_err
);
  localparam int NW = $clog2(DBIT + 1);
  localparam logic [4:0]    C_MID       = 5'(MID_TICK);
  localparam logic [4:0]    C_DATA_LAST = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    C_STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] C_BIT_LAST  = NW'(DBIT - 1);

  rx_state_t       r_state, w_state_nx;
  logic [4:0]      r_s_cnt, w_s_cnt_nx;
  logic [NW-1:0]   r_n_cnt, w_n_cnt_nx;
  logic [DBIT-1:0] r_shift, w_shift_nx;
  logic [DBIT-1:0] r_dout,  w_dout_nx;
  logic            r_armed, w_armed_nx;
  logic            r_done,  w_done_nx;
  logic            r_ferr,  w_ferr_nx;
  logic            w_rx_s;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  always_comb begin
    w_state_nx = r_state;
    w_s_cnt_nx = r_s_cnt;
    w_n_cnt_nx = r_n_cnt;
    w_shift_nx = r_shift;
    w_dout_nx  = r_dout;
    w_armed_nx = r_armed;
    w_done_nx  = 1'b0;
    w_ferr_nx  = r_ferr;
    unique case (r_state)
      IDLE: begin
        // Arming requires a high line first, so a held break cannot retrigger frames.
        if (r_armed && !w_rx_s) begin
          w_state_nx = START;
          w_s_cnt_nx = '0;
          w_armed_nx = 1'b0;
        end else if (w_rx_s) begin
          w_armed_nx = 1'b1;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s_cnt == C_MID) begin
            w_s_cnt_nx = '0;
            if (!w_rx_s) begin
              w_state_nx = DATA;
              w_n_cnt_nx = '0;
            end else begin
              w_state_nx = IDLE;
            end
          end else begin
            w_s_cnt_nx = r_s_cnt + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s_cnt == C_DATA_LAST) begin
            w_shift_nx = {w_rx_s, r_shift[DBIT-1:1]};
            w_s_cnt_nx = '0;
            if (r_n_cnt == C_BIT_LAST) w_state_nx = STOP;
            else                       w_n_cnt_nx = r_n_cnt + NW'(1);
          end else begin
            w_s_cnt_nx = r_s_cnt + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (r_s_cnt == C_STOP_LAST) begin
            w_dout_nx  = r_shift;
            w_done_nx  = 1'b1;
            w_ferr_nx  = ~w_rx_s;
            w_s_cnt_nx = '0;
            w_state_nx = IDLE;
          end else begin
            w_s_cnt_nx = r_s_cnt + 5'd1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_armed <= 1'b0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_s_cnt <= w_s_cnt_nx;
      r_n_cnt <= w_n_cnt_nx;
      r_shift <= w_shift_nx;
      r_dout  <= w_dout_nx;
      r_armed <= w_armed_nx;
      r_done  <= w_done_nx;
      r_ferr  <= w_ferr_nx;
    end
  end

  assign rx_dout      = r_dout;
  assign rx_done_tick = r_done;
  assign framing_err  = r_ferr;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames are queued as expected words, a monitor pops on each done pulse.
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick;
  logic [7:0] rx_dout;
  logic       rx_done_tick;
  logic       framing_err;

  logic [1:0] div = 2'd0;
  assign s_tick = (div == 2'd3);

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .framing_err  (framing_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   lat_arm = 1'b0;
  bit   lat_pend = 1'b0;
  int   fall_cyc = 0;
  int   lat_ticks = 0;
  int   exp_done_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Edge index counter plus a tick counter that predicts the done edge for the timed frame:
  // START is entered 3 edges after the line falls, then 8+8*16+16 ticks complete the frame.
  always @(posedge clk) begin
    cyc = cyc + 1;
    div <= div + 2'd1;
    if (lat_arm && s_tick && cyc >= fall_cyc + 4) begin
      lat_ticks = lat_ticks + 1;
      if (lat_ticks == 152) begin
        exp_done_cyc = cyc;
        lat_arm = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rx_done_tick) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got dout=0x%0h ferr=%0b, expected no pulse", rx_dout, framing_err);
      end else begin
        mon_e = sb_q.pop_front();
        check("rx_dout", int'(rx_dout), int'(mon_e.d));
        check("framing_err", int'(framing_err), int'(mon_e.fe));
        if (lat_pend) begin
          check("done_latency_cycle", cyc, exp_done_cyc);
          lat_pend = 1'b0;
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves rx at the stop level so back-to-back frames follow with no gap.
  task automatic send(input logic [7:0] d, input logic stop, input int bc, input bit timed);
    exp_t e;
    e.d  = d;
    e.fe = ~stop;
    sb_q.push_back(e);
    if (timed) begin
      fall_cyc  = cyc;
      lat_ticks = 0;
      lat_arm   = 1'b1;
      lat_pend  = 1'b1;
    end
    rx = 1'b0;
    wait_clk(bc);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(bc);
    end
    rx = stop;
    wait_clk(bc);
  endtask

  initial begin
    logic [7:0] ab;
    reset_n = 1'b0;
    rx = 1'b1;
    wait_clk(5);
    check("reset_dout", int'(rx_dout), 0);
    check("reset_done", int'(rx_done_tick), 0);
    check("reset_ferr", int'(framing_err), 0);
    reset_n = 1'b1;
    wait_clk(20);

    // Single frame with latency check
    send(8'hA5, 1'b1, 64, 1'b1);
    rx = 1'b1;
    wait_clk(128);
    check("a5_queue_empty", sb_q.size(), 0);

    // Back-to-back frames, no idle gap
    send(8'h00, 1'b1, 64, 1'b0);
    send(8'hFF, 1'b1, 64, 1'b0);
    rx = 1'b1;
    wait_clk(128);

    // Short low glitch must be rejected at the start-bit centre
    rx = 1'b0;
    wait_clk(12);
    rx = 1'b1;
    wait_clk(640);
    check("glitch_dout_held", int'(rx_dout), 8'hFF);
    check("glitch_no_pulse", sb_q.size(), 0);

    // Framing error, then a long break that must not retrigger
    send(8'h3C, 1'b0, 64, 1'b0);
    wait_clk(40 * 64);
    check("break_dout_held", int'(rx_dout), 8'h3C);
    check("break_ferr_held", int'(framing_err), 1);
    rx = 1'b1;
    wait_clk(128);
    send(8'h55, 1'b1, 64, 1'b0);
    rx = 1'b1;
    wait_clk(128);

    // Reset in the middle of data bit 4 abandons the frame silently
    ab = 8'h66;
    rx = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 4; i++) begin
      rx = ab[i];
      wait_clk(64);
    end
    rx = ab[4];
    wait_clk(32);
    reset_n = 1'b0;
    wait_clk(1);
    check("midreset_dout", int'(rx_dout), 0);
    check("midreset_done", int'(rx_done_tick), 0);
    check("midreset_ferr", int'(framing_err), 0);
    reset_n = 1'b1;
    rx = 1'b1;
    wait_clk(3 * 64);
    check("midreset_no_pulse", int'(rx_dout), 0);
    send(8'h81, 1'b1, 64, 1'b0);
    rx = 1'b1;
    wait_clk(128);

    // Bit period skewed about +/-3%
    send(8'h5A, 1'b1, 62, 1'b0);
    rx = 1'b1;
    wait_clk(128);
    send(8'h5A, 1'b1, 66, 1'b0);
    rx = 1'b1;
    wait_clk(128);

    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) wait_clk(1);
    check("queue_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
